// File: rtl/handshake_sched_pkg.sv
// Shared types and default sizing for the handshake scheduler slice.
package handshake_sched_pkg;

  localparam int DEFAULT_NREQ    = 4;
  localparam int DEFAULT_ACK_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK_WAIT,
    DONE_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/handshake_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import handshake_sched_pkg::*;
#(
  parameter int N  = DEFAULT_NREQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_sched.sv
// Round-robin scheduler granting one client at a time a req/ack/done
// handshake on a shared resource, with ack timeout and error counting.
module handshake_sched
  import handshake_sched_pkg::*;
#(
  parameter int NREQ    = DEFAULT_NREQ,
  parameter int ACK_MAX = DEFAULT_ACK_MAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic [NREQ-1:0]         err_o,
  output logic                    res_req,
  output logic [$clog2(NREQ)-1:0] res_sel,
  input  logic                    res_ack,
  input  logic                    res_done,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam int SEL_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(ACK_MAX + 1);

  state_t            state, state_n;
  logic [SEL_W-1:0]  sel_q, sel_n;
  logic [SEL_W-1:0]  ptr_q, ptr_n;
  logic [SEL_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              fail_q, fail_n;
  logic [7:0]        err_cnt_q, err_cnt_n;
  logic [NREQ-1:0]   sel_onehot;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req_i),
    .ptr   (ptr_q),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      fail_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state     <= state_n;
      sel_q     <= sel_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      fail_q    <= fail_n;
      err_cnt_q <= err_cnt_n;
    end
  end

  // Acks/dones are only looked at in their own wait state, so strays elsewhere are dropped.
  always_comb begin
    state_n   = state;
    sel_n     = sel_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    fail_n    = fail_q;
    err_cnt_n = err_cnt_q;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          sel_n   = arb_idx;
          state_n = REQ;
        end
      end
      REQ: begin
        cnt_n   = '0;
        fail_n  = 1'b0;
        state_n = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (res_ack) begin
          state_n = DONE_WAIT;
        end else if (cnt_q == CNT_W'(ACK_MAX - 1)) begin
          fail_n  = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DONE_WAIT: begin
        fail_n  = !res_done;
        state_n = RESP;
      end
      RESP: begin
        if (fail_q && err_cnt_q != 8'hFF) err_cnt_n = err_cnt_q + 8'd1;
        ptr_n   = (sel_q == SEL_W'(NREQ - 1)) ? '0 : sel_q + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign sel_onehot = NREQ'(1) << sel_q;

  always_comb begin
    gnt_o   = '0;
    done_o  = '0;
    err_o   = '0;
    res_req = 1'b0;
    busy    = (state != IDLE);
    if (state != IDLE) gnt_o = sel_onehot;
    if (state == REQ) res_req = 1'b1;
    if (state == RESP) begin
      if (fail_q) err_o  = sel_onehot;
      else        done_o = sel_onehot;
    end
  end

  assign res_sel = sel_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_handshake_sched.sv
// Directed, table-driven bench for handshake_sched (NREQ=4, ACK_MAX=3);
// inputs are driven and outputs sampled on the falling clock edge.
module tb_handshake_sched;

  localparam int NREQ    = 4;
  localparam int ACK_MAX = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_i;
  logic [3:0] gnt_o, done_o, err_o;
  logic       res_req;
  logic [1:0] res_sel;
  logic       res_ack, res_done;
  logic       busy;
  logic [7:0] err_cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  handshake_sched #(.NREQ(NREQ), .ACK_MAX(ACK_MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .res_req  (res_req),
    .res_sel  (res_sel),
    .res_ack  (res_ack),
    .res_done (res_done),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       done;
    logic [3:0] gnt;
    logic [3:0] dn;
    logic [3:0] er;
    logic       rreq;
    logic [1:0] sel;
    logic       bsy;
    logic [7:0] ecnt;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic [3:0] req, logic ack, logic done,
                              logic [3:0] gnt, logic [3:0] dn, logic [3:0] er,
                              logic rreq, logic [1:0] sel, logic bsy, logic [7:0] ecnt);
    vec_t v;
    v.req = req; v.ack = ack; v.done = done;
    v.gnt = gnt; v.dn = dn; v.er = er; v.rreq = rreq;
    v.sel = sel; v.bsy = bsy; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i);
    req_i    = vecs[i].req;
    res_ack  = vecs[i].ack;
    res_done = vecs[i].done;
  endtask

  task automatic checkOutput(input int i);
    logic [31:0] act, exp;
    act = {8'd0, gnt_o, done_o, err_o, res_req, res_sel, busy, err_cnt};
    exp = {8'd0, vecs[i].gnt, vecs[i].dn, vecs[i].er, vecs[i].rreq,
           vecs[i].sel, vecs[i].bsy, vecs[i].ecnt};
    checkVal($sformatf("row %0d {gnt,done,err,res_req,sel,busy,err_cnt}", i), act, exp);
  endtask

  // k = cycle of ACK_WAIT carrying the ack (0 = never ack, forcing a timeout)
  task automatic runTxn(input int k, input bit doneBit, input logic [1:0] expSel,
                        input bit expFail, input string tag);
    bit         seen;
    logic [3:0] oh;
    seen = 1'b0;
    oh   = 4'b0001 << expSel;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (res_req === 1'b1) seen = 1'b1;
    end
    checkVal({tag, " res_req seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    checkVal({tag, " res_sel"}, 32'(res_sel), 32'(expSel));
    res_ack  = 1'b0;
    res_done = 1'b0;
    if (k == 0) begin
      repeat (ACK_MAX + 1) @(negedge clk);
    end else begin
      for (int c = 1; c <= k; c++) begin
        @(negedge clk);
        res_ack = (c == k);
      end
      @(negedge clk);
      res_ack  = 1'b0;
      res_done = doneBit;
      @(negedge clk);
      res_done = 1'b0;
    end
    checkVal({tag, " err_o"},  32'(err_o),  expFail ? 32'(oh) : 32'd0);
    checkVal({tag, " done_o"}, 32'(done_o), expFail ? 32'd0 : 32'(oh));
    @(negedge clk);
    checkVal({tag, " idle after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    //            req    ack  dn     gnt    done   err   rreq sel bsy ecnt
    vecs[0]  = mk(4'h1, 0, 0,  4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    vecs[1]  = mk(4'h1, 1, 0,  4'h1, 4'h0, 4'h0, 1, 0, 1, 0);
    vecs[2]  = mk(4'h1, 0, 0,  4'h1, 4'h0, 4'h0, 0, 0, 1, 0);
    vecs[3]  = mk(4'h1, 1, 0,  4'h1, 4'h0, 4'h0, 0, 0, 1, 0);
    vecs[4]  = mk(4'h1, 0, 1,  4'h1, 4'h0, 4'h0, 0, 0, 1, 0);
    vecs[5]  = mk(4'h0, 0, 0,  4'h1, 4'h1, 4'h0, 0, 0, 1, 0);
    vecs[6]  = mk(4'h0, 1, 1,  4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    vecs[7]  = mk(4'h4, 0, 0,  4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    vecs[8]  = mk(4'h4, 1, 1,  4'h4, 4'h0, 4'h0, 1, 2, 1, 0);
    vecs[9]  = mk(4'h4, 0, 0,  4'h4, 4'h0, 4'h0, 0, 2, 1, 0);
    vecs[10] = mk(4'h4, 0, 0,  4'h4, 4'h0, 4'h0, 0, 2, 1, 0);
    vecs[11] = mk(4'h4, 0, 0,  4'h4, 4'h0, 4'h0, 0, 2, 1, 0);
    vecs[12] = mk(4'h9, 0, 0,  4'h4, 4'h0, 4'h4, 0, 2, 1, 0);
    vecs[13] = mk(4'h9, 0, 0,  4'h0, 4'h0, 4'h0, 0, 2, 0, 1);
    vecs[14] = mk(4'h9, 0, 0,  4'h8, 4'h0, 4'h0, 1, 3, 1, 1);
    vecs[15] = mk(4'h9, 1, 1,  4'h8, 4'h0, 4'h0, 0, 3, 1, 1);
    vecs[16] = mk(4'h9, 0, 0,  4'h8, 4'h0, 4'h0, 0, 3, 1, 1);
    vecs[17] = mk(4'h1, 0, 0,  4'h8, 4'h0, 4'h8, 0, 3, 1, 1);
    vecs[18] = mk(4'h1, 0, 0,  4'h0, 4'h0, 4'h0, 0, 3, 0, 2);
    vecs[19] = mk(4'h0, 0, 0,  4'h1, 4'h0, 4'h0, 1, 0, 1, 2);
    vecs[20] = mk(4'h0, 1, 1,  4'h1, 4'h0, 4'h0, 0, 0, 1, 2);
    vecs[21] = mk(4'h0, 0, 1,  4'h1, 4'h0, 4'h0, 0, 0, 1, 2);
    vecs[22] = mk(4'h0, 0, 0,  4'h1, 4'h1, 4'h0, 0, 0, 1, 2);
    vecs[23] = mk(4'h0, 0, 0,  4'h0, 4'h0, 4'h0, 0, 0, 0, 2);

    reset    = 1'b1;
    req_i    = '0;
    res_ack  = 1'b0;
    res_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      checkOutput(i);
      applyStimulus(i);
    end

    // Reset landing in DONE_WAIT must abandon the transaction silently.
    @(negedge clk);
    checkVal("idle before reset test", 32'(busy), 32'd0);
    req_i = 4'b0010;
    @(negedge clk);
    checkVal("mid-reset REQ res_req", 32'(res_req), 32'd1);
    checkVal("mid-reset REQ res_sel", 32'(res_sel), 32'd1);
    @(negedge clk);
    res_ack = 1'b1;
    @(negedge clk);
    checkVal("mid-reset DONE_WAIT gnt", 32'(gnt_o), 32'h2);
    res_ack  = 1'b0;
    res_done = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    checkVal("outputs after reset",
             {8'd0, gnt_o, done_o, err_o, res_req, res_sel, busy, err_cnt}, 32'd0);
    reset    = 1'b0;
    res_done = 1'b0;
    req_i    = '0;
    @(negedge clk);
    checkVal("no pulse after reset", {20'd0, done_o, err_o, 3'd0, busy}, 32'd0);

    // rr_ptr back at 0: all clients requesting are served in index order.
    req_i = 4'b1111;
    runTxn(1, 1'b1, 2'd0, 1'b0, "rr0");
    runTxn(1, 1'b1, 2'd1, 1'b0, "rr1");
    runTxn(2, 1'b1, 2'd2, 1'b0, "rr2");
    runTxn(3, 1'b1, 2'd3, 1'b0, "rr3");
    runTxn(1, 1'b1, 2'd0, 1'b0, "rr4");

    req_i = 4'b0001;
    for (int i = 0; i < 260; i++) begin
      runTxn(0, 1'b0, 2'd0, 1'b1, "sat");
      if (i == 199) checkVal("err_cnt after 200 timeouts", 32'(err_cnt), 32'd200);
    end
    checkVal("err_cnt saturated", 32'(err_cnt), 32'd255);
    req_i = '0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/handshake_sched.md
HANDSHAKE_SCHED -- requirements
Module: handshake_sched

Interface
REQ-001 NREQ, 4, number of requesters (2..8).
REQ-002 ACK_MAX, 3, maximum cycles from res_req to res_ack (1..15).
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_i  input  NREQ  per-client request, level; held until done_o or err_o.
REQ-006 gnt_o  output  NREQ  one-hot grant to the client being served.
REQ-007 done_o  output  NREQ  one-cycle pulse to the served client on success.
REQ-008 err_o  output  NREQ  one-cycle pulse to the served client on failure.
REQ-009 res_req  output  1  one-cycle request pulse to the shared resource.
REQ-010 res_sel  output  $clog2(NREQ)  index of the served client; stable while gnt_o is nonzero.
REQ-011 res_ack  input  1  resource acknowledge.
REQ-012 res_done  input  1  resource completion.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err_cnt  output  8  count of failed transactions; saturates at 255.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, ACK_WAIT, DONE_WAIT and RESP.
REQ-016 IDLE: if any req_i bit is set, the FSM SHALL pick the first set bit at or after rr_ptr (wrapping), latch it into res_sel and go to REQ.
REQ-017 REQ: the FSM SHALL assert res_req for exactly this one cycle, clear the wait counter and go to ACK_WAIT; res_ack sampled in this cycle is ignored.
REQ-018 ACK_WAIT: on res_ack, go to DONE_WAIT.
REQ-019 ACK_WAIT timeout: if res_ack is absent for ACK_MAX consecutive cycles, go to RESP with fail=1.
REQ-020 DONE_WAIT lasts exactly one cycle: res_done high gives fail=0, res_done low gives fail=1; the FSM then goes to RESP.
REQ-021 RESP: pulse done_o[res_sel] if fail=0, else err_o[res_sel] and increment err_cnt (saturating); then set rr_ptr = (res_sel+1) mod NREQ and go to IDLE.
REQ-022 gnt_o[res_sel] SHALL be high from REQ through RESP inclusive and zero in IDLE.
REQ-023 Latency: req_i seen in IDLE cycle t gives res_req at t+1, ack at t+1+k (k = 1..ACK_MAX), done at t+2+k, done_o at t+3+k and IDLE at t+4+k.
REQ-024 res_ack and res_done arriving together in ACK_WAIT: the ack is accepted, that res_done is ignored, and res_done is still required in DONE_WAIT.
REQ-025 res_ack or res_done outside ACK_WAIT or DONE_WAIT SHALL be ignored and cause no state change.
REQ-026 A client dropping req_i while granted SHALL NOT abort the transaction; done_o or err_o is still pulsed.
REQ-027 Requests arriving in non-IDLE states SHALL wait; arbitration happens only in IDLE, so there is a minimum one IDLE cycle between transactions.
REQ-028 done_o | err_o SHALL have at most one bit set in any cycle and never both for the same client.

Reset
REQ-029 While reset is high, on the next posedge: state=IDLE, rr_ptr=0, res_sel=0, counter=0, err_cnt=0, and all outputs 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no done_o or err_o pulse, and reset takes priority over every transition.

Structure
REQ-031 Package handshake_sched_pkg SHALL hold the state enum type and the default NREQ and ACK_MAX constants.
REQ-032 Round-robin selection SHALL live in a combinational sub-module rr_arbiter (inputs req and ptr; outputs idx and valid).
REQ-033 The wait counter SHALL be $clog2(ACK_MAX+1) bits wide.

Verification
REQ-034 req_i=0001, ack 2 cycles after res_req, done next cycle -> gnt_o=0001, res_sel=0, done_o=0001 pulse at t+5, err_cnt=0.
REQ-035 req_i=1111 held, each transaction completing, over 4 transactions -> res_sel sequence 0,1,2,3, then 0 again.
REQ-036 No res_ack for 3 cycles (ACK_MAX=3) -> err_o[res_sel] pulse, err_cnt=1, next grant goes to the next index.
REQ-037 res_ack then no res_done in the next cycle -> err_o pulse; res_ack and res_done together, then res_done next cycle -> done_o pulse.
REQ-038 reset asserted in DONE_WAIT -> next cycle all outputs 0 and IDLE, no done_o/err_o pulse, rr_ptr=0.
REQ-039 260 forced timeouts -> err_cnt saturates at 255.
